// File: rtl/lab1_imul_mul_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// lab1_imul_mul_arbiter_pkg
//
// Shared types for the multiplier arbiter slice:
//   lab1_imul_req_msg_t  : 64-bit multiply request, a = [63:32], b = [31:0]
//   lab1_imul_resp_msg_t : 32-bit multiply result (low 32 bits of a*b)
//   owner_id_t           : 1-bit requester id (port 0 / port 1)
// -----------------------------------------------------------------------------
package lab1_imul_mul_arbiter_pkg;

  typedef logic [63:0] lab1_imul_req_msg_t;
  typedef logic [31:0] lab1_imul_resp_msg_t;
  typedef logic        owner_id_t;

  localparam owner_id_t OWNER_P0 = 1'b0;
  localparam owner_id_t OWNER_P1 = 1'b1;

  // Pack operands into a request message.
  function automatic lab1_imul_req_msg_t mk_req(input logic [31:0] a, input logic [31:0] b);
    return {a, b};
  endfunction

endpackage

// File: rtl/lab1_imul_mul_arbiter_if.sv
// -----------------------------------------------------------------------------
// lab1_imul_mul_arbiter_if
//
// One val/rdy request channel plus its val/rdy response channel.
//   master : issues requests (drives req_val/req_msg), accepts responses
//            (drives resp_rdy)
//   slave  : accepts requests (drives req_rdy), returns responses
//            (drives resp_val/resp_msg)
// The arbiter is the slave of each requester and the master of the
// multiplier.
// -----------------------------------------------------------------------------
interface lab1_imul_mul_arbiter_if;
  import lab1_imul_mul_arbiter_pkg::*;

  logic                req_val;
  logic                req_rdy;
  lab1_imul_req_msg_t  req_msg;
  logic                resp_val;
  logic                resp_rdy;
  lab1_imul_resp_msg_t resp_msg;

  modport master (
    output req_val, req_msg, resp_rdy,
    input  req_rdy, resp_val, resp_msg
  );

  modport slave (
    input  req_val, req_msg, resp_rdy,
    output req_rdy, resp_val, resp_msg
  );

endinterface

// File: rtl/lab1_imul_owner_fifo.sv
// -----------------------------------------------------------------------------
// lab1_imul_owner_fifo
//
// Records which requester owns each transaction in flight to the multiplier.
// Depth p_depth (power of two, >= 1), 1-bit entries.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   enq_val    : push enq_data (ignored when full, even if a pop happens in
//                the same cycle, so full never depends on the pop path)
//   deq_val    : pop the head (ignored when empty)
//   deq_data   : current head entry (stale when empty)
//   full/empty : occupancy flags, registered-state only
//   count      : number of occupied entries
// -----------------------------------------------------------------------------
module lab1_imul_owner_fifo
  import lab1_imul_mul_arbiter_pkg::*;
#(
  parameter  int unsigned p_depth = 2,
  localparam int unsigned CNT_W   = $clog2(p_depth + 1),
  localparam int unsigned PTR_W   = (p_depth > 1) ? $clog2(p_depth) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_val,
  input  owner_id_t        enq_data,
  input  logic             deq_val,
  output owner_id_t        deq_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [p_depth-1:0] mem_q,  mem_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   cnt_q,  cnt_d;
  logic               do_enq, do_deq;

  // Explicit wrap so non-power-of-two slips or depth 1 still behave.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(p_depth - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    full     = (cnt_q == CNT_W'(p_depth));
    empty    = (cnt_q == '0);
    count    = cnt_q;
    deq_data = mem_q[head_q];
    do_enq   = enq_val && !full;
    do_deq   = deq_val && !empty;
  end

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    if (do_enq) begin
      mem_d[tail_q] = enq_data;
      tail_d        = ptr_inc(tail_q);
    end
    if (do_deq) begin
      head_d = ptr_inc(head_q);
    end
    cnt_d = cnt_q + CNT_W'(do_enq) - CNT_W'(do_deq);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage is only meaningful below cnt_q, so it needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/lab1_imul_mul_arbiter.sv
// -----------------------------------------------------------------------------
// lab1_imul_mul_arbiter
//
// Shares one integer multiplier between two requesters. Requests are granted
// round-robin; the owner of each forwarded request is pushed onto an owner
// FIFO, and multiplier responses (which must return in request order) are
// steered back to the owner at the FIFO head. Zero added latency each way.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset; while reset is
//                     high every val/rdy output is held at 0
//   in0, in1        : requester channels (slave side)
//   mul             : multiplier channel (master side)
//   trace_prio      : current round-robin favourite (0 = port 0)
//   trace_count     : owner FIFO occupancy
//   trace_head      : owner id at the FIFO head (0 when empty)
//   trace_proto_err : multiplier response offered with nothing in flight;
//                     the response is ignored
// -----------------------------------------------------------------------------
module lab1_imul_mul_arbiter
  import lab1_imul_mul_arbiter_pkg::*;
#(
  parameter  int unsigned p_max_inflight = 2,
  localparam int unsigned CNT_W          = $clog2(p_max_inflight + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  lab1_imul_mul_arbiter_if.slave  in0,
  lab1_imul_mul_arbiter_if.slave  in1,
  lab1_imul_mul_arbiter_if.master mul,
  output logic                    trace_prio,
  output logic [CNT_W-1:0]        trace_count,
  output owner_id_t               trace_head,
  output logic                    trace_proto_err
);

  owner_id_t        prio_q, prio_d;
  owner_id_t        winner;
  owner_id_t        head;
  logic             any_val;
  logic             can_issue;
  logic             req_fire;
  logic             resp_fire;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  lab1_imul_owner_fifo #(
    .p_depth (p_max_inflight)
  ) u_owner_fifo (
    .clk      (clk),
    .reset    (reset),
    .enq_val  (req_fire),
    .enq_data (winner),
    .deq_val  (resp_fire),
    .deq_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Grant: full comes from registered occupancy only, so nothing on the
  // response side can reach any req_rdy combinationally.
  always_comb begin
    any_val = in0.req_val || in1.req_val;
    winner  = OWNER_P0;
    if (in0.req_val && in1.req_val) begin
      winner = prio_q;
    end else if (in1.req_val) begin
      winner = OWNER_P1;
    end

    can_issue   = !reset && mul.req_rdy && !fifo_full;
    mul.req_val = !reset && any_val && !fifo_full;
    mul.req_msg = '0;
    if (any_val) begin
      mul.req_msg = (winner == OWNER_P1) ? in1.req_msg : in0.req_msg;
    end

    in0.req_rdy = can_issue && any_val && (winner == OWNER_P0);
    in1.req_rdy = can_issue && any_val && (winner == OWNER_P1);
    req_fire    = mul.req_val && mul.req_rdy;
  end

  // Round-robin: after each grant the other port is favoured.
  always_comb begin
    prio_d = prio_q;
    if (req_fire) begin
      prio_d = ~winner;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= OWNER_P0;
    end else begin
      prio_q <= prio_d;
    end
  end

  // Response steering: only the head owner sees the multiplier response,
  // and the multiplier is back-pressured by that owner alone.
  always_comb begin
    in0.resp_val = 1'b0;
    in1.resp_val = 1'b0;
    in0.resp_msg = '0;
    in1.resp_msg = '0;
    mul.resp_rdy = 1'b0;
    if (!fifo_empty) begin
      if (head == OWNER_P1) begin
        in1.resp_val = !reset && mul.resp_val;
        in1.resp_msg = mul.resp_msg;
        mul.resp_rdy = !reset && in1.resp_rdy;
      end else begin
        in0.resp_val = !reset && mul.resp_val;
        in0.resp_msg = mul.resp_msg;
        mul.resp_rdy = !reset && in0.resp_rdy;
      end
    end
    resp_fire = mul.resp_val && mul.resp_rdy;
  end

  always_comb begin
    trace_prio      = prio_q;
    trace_count     = fifo_count;
    trace_head      = fifo_empty ? OWNER_P0 : head;
    trace_proto_err = !reset && mul.resp_val && fifo_empty;
  end

endmodule

// File: tb/tb_lab1_imul_mul_arbiter.sv
`timescale 1ns/1ps
module tb_lab1_imul_mul_arbiter;
  import lab1_imul_mul_arbiter_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lab1_imul_mul_arbiter_if in0_if ();
  lab1_imul_mul_arbiter_if in1_if ();
  lab1_imul_mul_arbiter_if mul_if ();

  logic             trace_prio;
  logic [CNT_W-1:0] trace_count;
  owner_id_t        trace_head;
  logic             trace_proto_err;

  lab1_imul_mul_arbiter #(.p_max_inflight(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .in0             (in0_if),
    .in1             (in1_if),
    .mul             (mul_if),
    .trace_prio      (trace_prio),
    .trace_count     (trace_count),
    .trace_head      (trace_head),
    .trace_proto_err (trace_proto_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Stub multiplier: in-order queue of results, each available from its due cycle.
  typedef struct { logic [31:0] res; int due; } stub_item_t;
  stub_item_t stub_q[$];
  int   stub_lat      = 1;
  bit   stub_rand_lat = 0;
  logic stub_rdy      = 1'b1;

  // Reference model: favourite port and owner list of in-flight requests.
  bit m_prio;
  bit m_own[$];
  bit e_w, e_req_val, e_rdy0, e_rdy1, e_rv0, e_rv1, e_mrr;
  logic [63:0] e_req_msg;
  logic [31:0] e_rm0, e_rm1;

  // End-to-end scoreboard.
  logic [31:0] exp0[$], exp1[$], rx0[$], rx1[$];
  bit acc0, acc1;

  function automatic void model_eval();
    bit full, empty, anyv, head;
    full  = (m_own.size() == DEPTH);
    empty = (m_own.size() == 0);
    anyv  = in0_if.req_val || in1_if.req_val;
    e_w   = (in0_if.req_val && in1_if.req_val) ? m_prio : in1_if.req_val;
    head  = empty ? 1'b0 : m_own[0];
    e_req_val = !reset && anyv && !full;
    e_req_msg = !anyv ? 64'd0 : (e_w ? in1_if.req_msg : in0_if.req_msg);
    e_rdy0 = e_req_val && mul_if.req_rdy && !e_w;
    e_rdy1 = e_req_val && mul_if.req_rdy && e_w;
    e_rv0  = !reset && !empty && !head && mul_if.resp_val;
    e_rv1  = !reset && !empty &&  head && mul_if.resp_val;
    e_rm0  = (!empty && !head) ? mul_if.resp_msg : 32'd0;
    e_rm1  = (!empty &&  head) ? mul_if.resp_msg : 32'd0;
    e_mrr  = !reset && !empty && (head ? in1_if.resp_rdy : in0_if.resp_rdy);
  endfunction

  task automatic settle();
    mul_if.req_rdy = stub_rdy;
    if (stub_q.size() > 0 && stub_q[0].due <= cyc) begin
      mul_if.resp_val = 1'b1;
      mul_if.resp_msg = stub_q[0].res;
    end else begin
      mul_if.resp_val = 1'b0;
      mul_if.resp_msg = $urandom;
    end
    #1;
    model_eval();
  endtask

  task automatic advance();
    bit mfire, rfire, f0, f1;
    logic [63:0] mmsg;
    logic [31:0] r0, r1, p0, p1, pm;
    int lat;
    mfire = mul_if.req_val && mul_if.req_rdy;
    mmsg  = mul_if.req_msg;
    rfire = mul_if.resp_val && mul_if.resp_rdy;
    f0 = in0_if.resp_val && in0_if.resp_rdy;  r0 = in0_if.resp_msg;
    f1 = in1_if.resp_val && in1_if.resp_rdy;  r1 = in1_if.resp_msg;
    acc0 = in0_if.req_val && in0_if.req_rdy;
    acc1 = in1_if.req_val && in1_if.req_rdy;
    p0 = in0_if.req_msg[63:32] * in0_if.req_msg[31:0];
    p1 = in1_if.req_msg[63:32] * in1_if.req_msg[31:0];
    pm = mmsg[63:32] * mmsg[31:0];
    @(posedge clk);
    cyc++;
    if (reset) begin
      m_prio = 1'b0;
      m_own.delete(); stub_q.delete();
      exp0.delete(); exp1.delete(); rx0.delete(); rx1.delete();
      acc0 = 1'b0; acc1 = 1'b0;
    end else begin
      if (mul_if.resp_val && e_mrr) void'(m_own.pop_front());
      if (e_req_val && mul_if.req_rdy) begin
        m_own.push_back(e_w);
        m_prio = !e_w;
      end
      if (rfire) void'(stub_q.pop_front());
      if (mfire) begin
        lat = stub_rand_lat ? int'($urandom_range(1, 5)) : stub_lat;
        stub_q.push_back('{res: pm, due: cyc - 1 + lat});
      end
      if (acc0) exp0.push_back(p0);
      if (acc1) exp1.push_back(p1);
      if (f0) rx0.push_back(r0);
      if (f1) rx1.push_back(r1);
    end
    #1;
  endtask

  task automatic drain(output bit ok);
    in0_if.req_val = 1'b0; in1_if.req_val = 1'b0;
    in0_if.resp_rdy = 1'b1; in1_if.resp_rdy = 1'b1;
    stub_rdy = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (m_own.size() == 0 && stub_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      settle();
      advance();
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    in0_if.req_val = 1'b0; in1_if.req_val = 1'b0;
    in0_if.resp_rdy = 1'b1; in1_if.resp_rdy = 1'b1;
    stub_rdy = 1'b1; stub_rand_lat = 1'b0;
    settle();
    advance();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in0_if.req_val = 1'b1; in0_if.req_msg = mk_req(32'd5, 32'd6);
    in1_if.req_val = 1'b1; in1_if.req_msg = mk_req(32'd7, 32'd8);
    in0_if.resp_rdy = 1'b1; in1_if.resp_rdy = 1'b1;
    stub_rdy = 1'b1;
    settle();
    n_checks++;
    if ({in0_if.req_rdy, in1_if.req_rdy, mul_if.req_val, mul_if.resp_rdy,
         in0_if.resp_val, in1_if.resp_val} !== 6'b0)
      begin n_fail++; $display("FAIL reset_outputs: got %b required 000000",
        {in0_if.req_rdy, in1_if.req_rdy, mul_if.req_val, mul_if.resp_rdy,
         in0_if.resp_val, in1_if.resp_val}); end
    advance();
    settle();
    n_checks++;
    if (trace_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d required 0", trace_count); end
    n_checks++;
    if (trace_prio !== 1'b0) begin n_fail++; $display("FAIL reset_prio: got %0d required 0", trace_prio); end
    advance();
    reset = 1'b0;
    in0_if.req_val = 1'b0; in1_if.req_val = 1'b0;
  endtask

  task automatic test_port0_only();
    stub_lat = 1;
    in0_if.req_val = 1'b1; in0_if.req_msg = mk_req(32'd3, 32'd4);
    settle();
    n_checks++;
    if (mul_if.req_val !== 1'b1 || mul_if.req_msg !== 64'h0000_0003_0000_0004)
      begin n_fail++; $display("FAIL p0_forward: got val=%0d msg=%h required val=1 msg=0000000300000004", mul_if.req_val, mul_if.req_msg); end
    n_checks++;
    if (in0_if.req_rdy !== 1'b1 || in1_if.req_rdy !== 1'b0)
      begin n_fail++; $display("FAIL p0_rdy: got rdy0=%0d rdy1=%0d required 1/0", in0_if.req_rdy, in1_if.req_rdy); end
    advance();
    in0_if.req_val = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      n_checks++;
      if (in1_if.resp_val !== 1'b0) begin n_fail++; $display("FAIL p0_other_resp: got in1_resp_val=%0d required 0", in1_if.resp_val); end
      advance();
    end
    n_checks++;
    if (rx0.size() != 1 || rx0[0] !== 32'd12)
      begin n_fail++; $display("FAIL p0_result: got n=%0d first=%0d required n=1 first=12", rx0.size(), (rx0.size() > 0) ? rx0[0] : 32'd0); end
    n_checks++;
    if (trace_prio !== 1'b1) begin n_fail++; $display("FAIL p0_prio: got %0d required 1", trace_prio); end
  endtask

  task automatic test_alternate();
    bit ok;
    pulse_reset();
    stub_lat = 1;
    in0_if.req_val = 1'b1; in0_if.req_msg = mk_req(32'd2, 32'd5);
    in1_if.req_val = 1'b1; in1_if.req_msg = mk_req(32'd7, 32'd6);
    for (int i = 0; i < 8; i++) begin
      settle();
      n_checks++;
      if (in0_if.req_rdy !== (i % 2 == 0) || in1_if.req_rdy !== (i % 2 == 1))
        begin n_fail++; $display("FAIL alt_grant[%0d]: got rdy0=%0d rdy1=%0d required %0d/%0d", i, in0_if.req_rdy, in1_if.req_rdy, (i % 2 == 0), (i % 2 == 1)); end
      advance();
    end
    drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL alt_drain: got timeout required drained"); end
    n_checks++;
    if (rx0.size() != 4 || rx1.size() != 4)
      begin n_fail++; $display("FAIL alt_counts: got n0=%0d n1=%0d required 4/4", rx0.size(), rx1.size()); end
    for (int i = 0; i < rx0.size(); i++) begin
      n_checks++;
      if (rx0[i] !== 32'd10) begin n_fail++; $display("FAIL alt_p0[%0d]: got %0d required 10", i, rx0[i]); end
    end
    for (int i = 0; i < rx1.size(); i++) begin
      n_checks++;
      if (rx1[i] !== 32'd42) begin n_fail++; $display("FAIL alt_p1[%0d]: got %0d required 42", i, rx1[i]); end
    end
  endtask

  task automatic test_latency_stall();
    bit ok;
    int acc, stalls;
    pulse_reset();
    stub_lat = 4;
    acc = 0; stalls = 0;
    in0_if.req_val = 1'b1; in0_if.req_msg = {$urandom, $urandom};
    for (int c = 0; c < 20 && acc < 3; c++) begin
      settle();
      n_checks++;
      if (in0_if.req_rdy !== e_rdy0) begin n_fail++; $display("FAIL stall_rdy[%0d]: got %0d required %0d", c, in0_if.req_rdy, e_rdy0); end
      if (!in0_if.req_rdy) stalls++;
      advance();
      if (acc0) begin
        acc++;
        in0_if.req_msg = {$urandom, $urandom};
        if (acc == 3) in0_if.req_val = 1'b0;
      end
    end
    n_checks++;
    if (acc != 3 || stalls != 3) begin n_fail++; $display("FAIL stall_count: got acc=%0d stalls=%0d required 3/3", acc, stalls); end
    drain(ok);
    n_checks++;
    if (!ok || rx0.size() != 3) begin n_fail++; $display("FAIL stall_drain: got ok=%0d n=%0d required 1/3", ok, rx0.size()); end
    for (int i = 0; i < rx0.size() && i < exp0.size(); i++) begin
      n_checks++;
      if (rx0[i] !== exp0[i]) begin n_fail++; $display("FAIL stall_order[%0d]: got %h required %h", i, rx0[i], exp0[i]); end
    end
  endtask

  task automatic test_full_simul_pop();
    bit ok;
    pulse_reset();
    stub_lat = 2;
    in1_if.req_val = 1'b1; in1_if.req_msg = {$urandom, $urandom};
    for (int c = 0; c < 4; c++) begin
      settle();
      if (c == 2) begin
        n_checks++;
        if (mul_if.resp_val !== 1'b1 || mul_if.resp_rdy !== 1'b1 || trace_count !== CNT_W'(2))
          begin n_fail++; $display("FAIL full_pop_setup: got rv=%0d rr=%0d cnt=%0d required 1/1/2", mul_if.resp_val, mul_if.resp_rdy, trace_count); end
        n_checks++;
        if (mul_if.req_val !== 1'b0 || in1_if.req_rdy !== 1'b0)
          begin n_fail++; $display("FAIL full_pop_block: got req_val=%0d rdy1=%0d required 0/0", mul_if.req_val, in1_if.req_rdy); end
      end
      if (c == 3) begin
        n_checks++;
        if (in1_if.req_rdy !== 1'b1 || trace_count !== CNT_W'(1))
          begin n_fail++; $display("FAIL full_pop_next: got rdy1=%0d cnt=%0d required 1/1", in1_if.req_rdy, trace_count); end
      end
      advance();
      if (acc1) in1_if.req_msg = {$urandom, $urandom};
    end
    drain(ok);
    n_checks++;
    if (!ok || rx1.size() != 3 || exp1.size() != 3) begin n_fail++; $display("FAIL full_drain: got ok=%0d n=%0d required 1/3", ok, rx1.size()); end
    for (int i = 0; i < rx1.size() && i < exp1.size(); i++) begin
      n_checks++;
      if (rx1[i] !== exp1[i]) begin n_fail++; $display("FAIL full_order[%0d]: got %h required %h", i, rx1[i], exp1[i]); end
    end
  endtask

  task automatic test_resp_backpressure();
    bit ok;
    logic [31:0] pa, pb;
    pulse_reset();
    stub_lat = 1;
    in1_if.resp_rdy = 1'b0;
    in1_if.req_val = 1'b1; in1_if.req_msg = {$urandom, $urandom};
    pa = in1_if.req_msg[63:32] * in1_if.req_msg[31:0];
    settle(); advance();
    in1_if.req_val = 1'b0;
    in0_if.req_val = 1'b1; in0_if.req_msg = {$urandom, $urandom};
    pb = in0_if.req_msg[63:32] * in0_if.req_msg[31:0];
    settle(); advance();
    in0_if.req_val = 1'b0;
    for (int c = 0; c < 5; c++) begin
      settle();
      n_checks++;
      if (in1_if.resp_val !== 1'b1 || in1_if.resp_msg !== pa || mul_if.resp_rdy !== 1'b0 || in0_if.resp_val !== 1'b0)
        begin n_fail++; $display("FAIL bp_hold[%0d]: got v1=%0d m1=%h mrr=%0d v0=%0d required 1/%h/0/0", c, in1_if.resp_val, in1_if.resp_msg, mul_if.resp_rdy, in0_if.resp_val, pa); end
      advance();
    end
    n_checks++;
    if (rx0.size() != 0) begin n_fail++; $display("FAIL bp_early: got n0=%0d required 0", rx0.size()); end
    drain(ok);
    n_checks++;
    if (!ok || rx1.size() != 1 || rx0.size() != 1 || rx1[0] !== pa || rx0[0] !== pb)
      begin n_fail++; $display("FAIL bp_result: got ok=%0d n1=%0d n0=%0d required 1/1/1 with %h,%h", ok, rx1.size(), rx0.size(), pa, pb); end
  endtask

  task automatic test_reset_inflight();
    bit ok;
    pulse_reset();
    stub_lat = 6;
    in1_if.req_val = 1'b1; in1_if.req_msg = {$urandom, $urandom};
    settle(); advance();
    in1_if.req_val = 1'b0;
    in0_if.req_val = 1'b1; in0_if.req_msg = {$urandom, $urandom};
    settle(); advance();
    settle();
    n_checks++;
    if (trace_count !== CNT_W'(2) || trace_prio !== 1'b1)
      begin n_fail++; $display("FAIL rst_pre: got cnt=%0d prio=%0d required 2/1", trace_count, trace_prio); end
    reset = 1'b1;
    in1_if.req_val = 1'b1;
    settle();
    n_checks++;
    if ({in0_if.req_rdy, in1_if.req_rdy, mul_if.req_val, mul_if.resp_rdy} !== 4'b0)
      begin n_fail++; $display("FAIL rst_inflight_out: got %b required 0000", {in0_if.req_rdy, in1_if.req_rdy, mul_if.req_val, mul_if.resp_rdy}); end
    advance();
    reset = 1'b0;
    in0_if.req_val = 1'b0; in1_if.req_val = 1'b0;
    settle();
    n_checks++;
    if (trace_count !== '0 || trace_prio !== 1'b0)
      begin n_fail++; $display("FAIL rst_post: got cnt=%0d prio=%0d required 0/0", trace_count, trace_prio); end
    advance();
    stub_lat = 1;
    in1_if.req_val = 1'b1; in1_if.req_msg = mk_req(32'hFFFF_FFFF, 32'd2);
    settle(); advance();
    in1_if.req_val = 1'b0;
    drain(ok);
    n_checks++;
    if (!ok || rx1.size() != 1 || rx1[0] !== 32'hFFFF_FFFE)
      begin n_fail++; $display("FAIL rst_after: got ok=%0d n=%0d v=%h required 1/1/fffffffe", ok, rx1.size(), (rx1.size() > 0) ? rx1[0] : 32'd0); end
  endtask

  task automatic test_random();
    bit ok;
    int bad;
    pulse_reset();
    stub_rand_lat = 1'b1;
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      if (!in0_if.req_val || acc0) begin
        in0_if.req_val = ($urandom_range(0, 3) != 0);
        in0_if.req_msg = {$urandom, $urandom};
      end
      if (!in1_if.req_val || acc1) begin
        in1_if.req_val = ($urandom_range(0, 3) != 0);
        in1_if.req_msg = {$urandom, $urandom};
      end
      in0_if.resp_rdy = ($urandom_range(0, 3) != 0);
      in1_if.resp_rdy = ($urandom_range(0, 3) != 0);
      stub_rdy = ($urandom_range(0, 4) != 0);
      settle();
      n_checks++;
      if ({mul_if.req_val, in0_if.req_rdy, in1_if.req_rdy, in0_if.resp_val, in1_if.resp_val, mul_if.resp_rdy} !==
          {e_req_val, e_rdy0, e_rdy1, e_rv0, e_rv1, e_mrr})
        begin n_fail++; $display("FAIL rnd_ctrl[%0d]: got %b required %b", c,
          {mul_if.req_val, in0_if.req_rdy, in1_if.req_rdy, in0_if.resp_val, in1_if.resp_val, mul_if.resp_rdy},
          {e_req_val, e_rdy0, e_rdy1, e_rv0, e_rv1, e_mrr}); end
      n_checks++;
      if (mul_if.req_msg !== e_req_msg || in0_if.resp_msg !== e_rm0 || in1_if.resp_msg !== e_rm1)
        begin n_fail++; $display("FAIL rnd_data[%0d]: got %h %h %h required %h %h %h", c,
          mul_if.req_msg, in0_if.resp_msg, in1_if.resp_msg, e_req_msg, e_rm0, e_rm1); end
      advance();
    end
    stub_rand_lat = 1'b0;
    stub_lat = 1;
    drain(ok);
    n_checks++;
    if (!ok || rx0.size() != exp0.size() || rx1.size() != exp1.size())
      begin n_fail++; $display("FAIL rnd_counts: got ok=%0d rx=%0d/%0d required 1 and %0d/%0d", ok, rx0.size(), rx1.size(), exp0.size(), exp1.size()); end
    for (int i = 0; i < rx0.size() && i < exp0.size(); i++) if (rx0[i] !== exp0[i]) bad++;
    for (int i = 0; i < rx1.size() && i < exp1.size(); i++) if (rx1[i] !== exp1[i]) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL rnd_results: got %0d wrong results required 0", bad); end
  endtask

  initial begin
    reset = 1'b1;
    in0_if.req_val = 1'b0; in0_if.req_msg = '0; in0_if.resp_rdy = 1'b0;
    in1_if.req_val = 1'b0; in1_if.req_msg = '0; in1_if.resp_rdy = 1'b0;
    mul_if.req_rdy = 1'b0; mul_if.resp_val = 1'b0; mul_if.resp_msg = '0;
    test_reset();
    test_port0_only();
    test_alternate();
    test_latency_stall();
    test_full_simul_pop();
    test_resp_backpressure();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion required finish before 400000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
